// File: rtl/mips_pkg.sv
// Shared types and constants for the data-memory bridge and its lane aligner.
package mips_pkg;

    localparam int N_DEF = 64;
    localparam int LANES = N_DEF / 8;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    // Address bits below the access size, i.e. the bits an aligned access keeps at zero.
    function automatic logic [2:0] size_lowmask(input size_t sz);
        case (sz)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational byte-lane logic: byte enables, store lane shift, load extract and extend.
module lane_align
    import mips_pkg::*;
#(
    parameter int N = 64,
    localparam int L = N / 8,
    localparam int OW = $clog2(L)
) (
    input  logic [1:0]    size,
    input  logic          uns,
    input  logic [OW-1:0] off,
    input  logic [N-1:0]  wdata_in,
    input  logic [N-1:0]  rdata_in,
    output logic [L-1:0]  be,
    output logic [N-1:0]  wdata_out,
    output logic [N-1:0]  rdata_out
);

    size_t         sz;
    logic [OW-1:0] aoff;
    logic [L-1:0]  base;
    logic [N-1:0]  shifted;
    logic          s;

    always_comb begin
        sz   = size_t'(size);
        // Offset bits below the access size are dropped, so a sloppy address silently aligns.
        aoff = off & ~OW'(size_lowmask(sz));
        base = L'(1);
        s    = 1'b0;
        case (sz)
            SZ_B:    base = L'(1);
            SZ_H:    base = L'(3);
            SZ_W:    base = L'(15);
            default: base = L'(255);
        endcase
        be        = base << aoff;
        wdata_out = wdata_in << {aoff, 3'b000};
        shifted   = rdata_in >> {aoff, 3'b000};
        rdata_out = shifted;
        case (sz)
            SZ_B: begin
                s         = ~uns & shifted[7];
                rdata_out = {{(N-8){s}}, shifted[7:0]};
            end
            SZ_H: begin
                s         = ~uns & shifted[15];
                rdata_out = {{(N-16){s}}, shifted[15:0]};
            end
            SZ_W: begin
                s         = ~uns & shifted[31];
                rdata_out = {{(N-32){s}}, shifted[31:0]};
            end
            default: rdata_out = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage load/store bridge to a doubleword data-memory bus with req/ack handshake.
// Define MISALIGN_CHK_EN to trap misaligned accesses instead of silently aligning them.
module dmem_bridge
    import mips_pkg::*;
#(
    parameter int N = 64,
    parameter int A = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           memreadM,
    input  logic           memwriteM,
    input  logic [1:0]     sizeM,
    input  logic           unsignedM,
    input  logic [N-1:0]   dataadr,
    input  logic [N-1:0]   writedata,
    output logic [N-1:0]   readdata,
    output logic           memstall,
    output logic           bus_req,
    output logic           bus_we,
    output logic [A-1:0]   bus_addr,
    output logic [N/8-1:0] bus_be,
    output logic [N-1:0]   bus_wdata,
    input  logic           bus_ack,
`ifdef MISALIGN_CHK_EN
    output logic           misalign,
`endif
    input  logic [N-1:0]   bus_rdata
);

    localparam int L  = N / 8;
    localparam int OW = $clog2(L);

    state_t        state_q, state_d;
    logic [A-1:0]  addr_q, addr_d;
    logic          we_q, we_d;
    logic [L-1:0]  be_q, be_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic [N-1:0]  rdata_q, rdata_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic [OW-1:0] off_q, off_d;

    logic          access, misal, misalign_c;
    logic          idle;
    logic [1:0]    la_size;
    logic          la_uns;
    logic [OW-1:0] la_off;
    logic [L-1:0]  la_be;
    logic [N-1:0]  la_wdata, la_rdata;
    logic          unused_hi;

    assign unused_hi = ^dataadr[N-1:A];

    // In IDLE the aligner works on the incoming request; afterwards on the latched one.
    assign idle    = (state_q == ST_IDLE);
    assign la_size = idle ? sizeM : size_q;
    assign la_uns  = idle ? unsignedM : uns_q;
    assign la_off  = idle ? dataadr[OW-1:0] : off_q;

    lane_align #(.N(N)) u_lane_align (
        .size      (la_size),
        .uns       (la_uns),
        .off       (la_off),
        .wdata_in  (writedata),
        .rdata_in  (bus_rdata),
        .be        (la_be),
        .wdata_out (la_wdata),
        .rdata_out (la_rdata)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        memstall   = 1'b0;
        misalign_c = 1'b0;
        access     = memreadM | memwriteM;
`ifdef MISALIGN_CHK_EN
        misal = |(dataadr[2:0] & size_lowmask(size_t'(sizeM)));
`else
        misal = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (access) begin
                    if (misal) begin
                        misalign_c = 1'b1;
                        rdata_d    = '0;
                    end else begin
                        memstall = 1'b1;
                        addr_d   = {dataadr[A-1:OW], {OW{1'b0}}};
                        we_d     = memwriteM;
                        be_d     = la_be;
                        wdata_d  = la_wdata;
                        size_d   = sizeM;
                        uns_d    = unsignedM;
                        off_d    = dataadr[OW-1:0];
                        state_d  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                memstall = 1'b1;
                if (bus_ack) begin
                    if (!we_q) rdata_d = la_rdata;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
        end
    end

    // Request is a pure decode of state so an async reset withdraws it immediately.
    assign bus_req   = (state_q == ST_BUSY);
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign readdata  = rdata_q;

`ifdef MISALIGN_CHK_EN
    assign misalign = misalign_c;
`else
    logic unused_misalign;
    assign unused_misalign = misalign_c;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed self-checking bench for dmem_bridge.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memreadM = 1'b0, memwriteM = 1'b0, unsignedM = 1'b0;
    logic [1:0]  sizeM = 2'b00;
    logic [63:0] dataadr = '0, writedata = '0, bus_rdata = '0;
    logic        bus_ack = 1'b0;
    logic [63:0] readdata, bus_wdata;
    logic        memstall, bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [7:0]  bus_be;
`ifdef MISALIGN_CHK_EN
    logic        misalign;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_bridge #(.N(64), .A(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .memreadM  (memreadM),
        .memwriteM (memwriteM),
        .sizeM     (sizeM),
        .unsignedM (unsignedM),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata),
        .memstall  (memstall),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
`ifdef MISALIGN_CHK_EN
        .misalign  (misalign),
`endif
        .bus_rdata (bus_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 reset = 1'b0;
        step(); step();
        chk("rst_bus_req", {63'd0, bus_req}, 64'd0);
        chk("rst_bus_we", {63'd0, bus_we}, 64'd0);
        chk("rst_bus_addr", {32'd0, bus_addr}, 64'd0);
        chk("rst_bus_be", {56'd0, bus_be}, 64'd0);
        chk("rst_bus_wdata", bus_wdata, 64'd0);
        chk("rst_readdata", readdata, 64'd0);
        chk("rst_memstall", {63'd0, memstall}, 64'd0);
        reset = 1'b1;
        step();

        // Word store at 0x1004, ack at cycle 3
        memwriteM = 1'b1; sizeM = 2'b10; dataadr = 64'h1004; writedata = 64'hDEADBEEF;
        #1;
        chk("ws_c0_memstall", {63'd0, memstall}, 64'd1);
        chk("ws_c0_req", {63'd0, bus_req}, 64'd0);
        step();
        chk("ws_c1_req", {63'd0, bus_req}, 64'd1);
        chk("ws_c1_we", {63'd0, bus_we}, 64'd1);
        chk("ws_addr", {32'd0, bus_addr}, 64'h1000);
        chk("ws_be", {56'd0, bus_be}, 64'hF0);
        chk("ws_wdata", bus_wdata, 64'hDEADBEEF_00000000);
        chk("ws_c1_memstall", {63'd0, memstall}, 64'd1);
        step();
        chk("ws_c2_memstall", {63'd0, memstall}, 64'd1);
        bus_ack = 1'b1;
        #1;
        chk("ws_c3_memstall", {63'd0, memstall}, 64'd1);
        step();
        bus_ack = 1'b0;
        chk("ws_c4_memstall", {63'd0, memstall}, 64'd0);
        chk("ws_c4_req", {63'd0, bus_req}, 64'd0);
        chk("ws_readdata", readdata, 64'd0);
        memwriteM = 1'b0;
        step();
        chk("ws_c5_req", {63'd0, bus_req}, 64'd0);

        // Signed then unsigned byte load at 0x2003
        for (int u = 0; u < 2; u++) begin
            memreadM = 1'b1; sizeM = 2'b00; unsignedM = u[0]; dataadr = 64'h2003;
            #1;
            chk("bl_c0_memstall", {63'd0, memstall}, 64'd1);
            step();
            chk("bl_addr", {32'd0, bus_addr}, 64'h2000);
            chk("bl_be", {56'd0, bus_be}, 64'h08);
            chk("bl_we", {63'd0, bus_we}, 64'd0);
            chk("bl_c1_memstall", {63'd0, memstall}, 64'd1);
            bus_ack = 1'b1; bus_rdata = 64'h00000000_80000000;
            step();
            bus_ack = 1'b0;
            chk("bl_readdata", readdata, (u == 0) ? 64'hFFFFFFFF_FFFFFF80 : 64'h80);
            chk("bl_done_memstall", {63'd0, memstall}, 64'd0);
            memreadM = 1'b0;
            step();
        end

        // Back-to-back: half load at 0x2006 then half store at 0x2002
        memreadM = 1'b1; sizeM = 2'b01; unsignedM = 1'b1; dataadr = 64'h2006;
        #1;
        chk("bb_ld_c0_memstall", {63'd0, memstall}, 64'd1);
        step();
        chk("bb_ld_req", {63'd0, bus_req}, 64'd1);
        chk("bb_ld_be", {56'd0, bus_be}, 64'hC0);
        bus_ack = 1'b1; bus_rdata = 64'hBEEF0000_00000000;
        step();
        bus_ack = 1'b0;
        chk("bb_ld_readdata", readdata, 64'hBEEF);
        chk("bb_ld_done_req", {63'd0, bus_req}, 64'd0);
        memreadM = 1'b0; memwriteM = 1'b1; dataadr = 64'h2002; writedata = 64'h1234;
        #1;
        chk("bb_done_memstall", {63'd0, memstall}, 64'd0);
        step();
        chk("bb_st_idle_memstall", {63'd0, memstall}, 64'd1);
        chk("bb_st_idle_req", {63'd0, bus_req}, 64'd0);
        step();
        chk("bb_st_req", {63'd0, bus_req}, 64'd1);
        chk("bb_st_be", {56'd0, bus_be}, 64'h0C);
        chk("bb_st_wdata", bus_wdata, 64'h12340000);
        bus_ack = 1'b1;
        step();
        bus_ack = 1'b0;
        chk("bb_st_done_memstall", {63'd0, memstall}, 64'd0);
        chk("bb_st_readdata", readdata, 64'hBEEF);
        memwriteM = 1'b0;
        step();
        chk("bb_after_req", {63'd0, bus_req}, 64'd0);

        // Spurious ack in IDLE
        bus_ack = 1'b1; bus_rdata = 64'h55555555_55555555;
        step();
        bus_ack = 1'b0;
        chk("sp_idle_req", {63'd0, bus_req}, 64'd0);
        chk("sp_idle_readdata", readdata, 64'hBEEF);
        chk("sp_idle_memstall", {63'd0, memstall}, 64'd0);

        // Signed word load at 0x3004
        memreadM = 1'b1; sizeM = 2'b10; unsignedM = 1'b0; dataadr = 64'h3004;
        step();
        chk("wl_be", {56'd0, bus_be}, 64'hF0);
        bus_ack = 1'b1; bus_rdata = 64'h80000001_12345678;
        step();
        bus_ack = 1'b0;
        chk("wl_readdata", readdata, 64'hFFFFFFFF_80000001);
        memreadM = 1'b0;
        step();

        // Dword load at 0x3000, ack held into DONE
        memreadM = 1'b1; sizeM = 2'b11; unsignedM = 1'b1; dataadr = 64'h3000;
        step();
        chk("dl_be", {56'd0, bus_be}, 64'hFF);
        chk("dl_addr", {32'd0, bus_addr}, 64'h3000);
        bus_ack = 1'b1; bus_rdata = 64'hFEDCBA98_76543210;
        step();
        chk("dl_readdata", readdata, 64'hFEDCBA98_76543210);
        memreadM = 1'b0; bus_rdata = 64'h11111111_11111111;
        step();
        bus_ack = 1'b0;
        chk("sp_done_readdata", readdata, 64'hFEDCBA98_76543210);
        chk("sp_done_req", {63'd0, bus_req}, 64'd0);
        chk("sp_done_memstall", {63'd0, memstall}, 64'd0);

`ifdef MISALIGN_CHK_EN
        // Misaligned word load traps in IDLE
        memreadM = 1'b1; sizeM = 2'b10; unsignedM = 1'b0; dataadr = 64'h4002;
        #1;
        chk("ma_flag", {63'd0, misalign}, 64'd1);
        chk("ma_memstall", {63'd0, memstall}, 64'd0);
        step();
        chk("ma_req", {63'd0, bus_req}, 64'd0);
        chk("ma_readdata", readdata, 64'd0);
        chk("ma_reflag", {63'd0, misalign}, 64'd1);
        memreadM = 1'b0;
        #1;
        chk("ma_clear", {63'd0, misalign}, 64'd0);
        step();
        chk("ma_req_after", {63'd0, bus_req}, 64'd0);
`else
        // Misaligned word load is silently aligned
        memreadM = 1'b1; sizeM = 2'b10; unsignedM = 1'b0; dataadr = 64'h4002;
        #1;
        chk("al_memstall", {63'd0, memstall}, 64'd1);
        step();
        chk("al_addr", {32'd0, bus_addr}, 64'h4000);
        chk("al_be", {56'd0, bus_be}, 64'h0F);
        bus_ack = 1'b1; bus_rdata = 64'h00000000_CAFEF00D;
        step();
        bus_ack = 1'b0;
        chk("al_readdata", readdata, 64'hFFFFFFFF_CAFEF00D);
        memreadM = 1'b0;
        step();
`endif

        // Reset asserted while BUSY
        memreadM = 1'b1; sizeM = 2'b11; dataadr = 64'h5000;
        step();
        chk("rb_req_before", {63'd0, bus_req}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rb_req_async", {63'd0, bus_req}, 64'd0);
        memreadM = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("rb_readdata", readdata, 64'd0);
        chk("rb_req", {63'd0, bus_req}, 64'd0);
        chk("rb_memstall", {63'd0, memstall}, 64'd0);
        chk("rb_be", {56'd0, bus_be}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
